// File: rtl/spike_pkg.sv
// Shared packet types, FSM states and pkt_data field-offset helpers for spike_tx.
// SPIKE_TX_EOT_EN adds the EOT packet type and FSM state.
package spike_pkg;

  typedef logic [1:0] pkt_type_t;

  localparam pkt_type_t PKT_SPIKE = 2'b01;

`ifdef SPIKE_TX_EOT_EN
  localparam pkt_type_t PKT_EOT = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EOT   = 2'd2
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1
  } tx_state_e;
`endif

  // pkt_data layout, MSB first: {type[1:0], node_id, neuron_id, ts}
  function automatic int pkt_width(input int node_w, input int neuron_w, input int ts_w);
    return 2 + node_w + neuron_w + ts_w;
  endfunction

  function automatic int ts_lsb();
    return 0;
  endfunction

  function automatic int neuron_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int node_lsb(input int neuron_w, input int ts_w);
    return ts_w + neuron_w;
  endfunction

  function automatic int type_lsb(input int node_w, input int neuron_w, input int ts_w);
    return ts_w + neuron_w + node_w;
  endfunction

endpackage

// File: rtl/spike_tx_if.sv
// Spike-in / packet-out link of spike_tx plus its status outputs.
// master = the environment driving spikes and router ready; slave = spike_tx.
interface spike_tx_if
  import spike_pkg::*;
#(
  parameter int NODE_ID_W   = 4,
  parameter int NEURON_ID_W = 8,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 8
);

  localparam int PKT_W = pkt_width(NODE_ID_W, NEURON_ID_W, TS_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                   spike_in_valid;
  logic [NEURON_ID_W-1:0] spike_in_id;
  logic [TS_W-1:0]        timestep;
  logic                   timestep_done;
  logic                   in_ready;
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [PKT_W-1:0]       pkt_data;
  logic [CNT_W-1:0]       fifo_count;
  logic [15:0]            drop_count;
  logic                   busy;

  modport master (
    output spike_in_valid, spike_in_id, timestep, timestep_done, pkt_ready,
    input  in_ready, pkt_valid, pkt_data, fifo_count, drop_count, busy
  );

  modport slave (
    input  spike_in_valid, spike_in_id, timestep, timestep_done, pkt_ready,
    output in_ready, pkt_valid, pkt_data, fifo_count, drop_count, busy
  );

endinterface

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module spike_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spike_tx.sv
// Spike transmitter: buffers neuron fire events and sends them as packets, draining
// at each timestep boundary. SPIKE_TX_EOT_EN appends an end-of-timestep packet.
module spike_tx
  import spike_pkg::*;
#(
  parameter int NODE_ID_W   = 4,
  parameter int NODE_ID     = 0,
  parameter int NEURON_ID_W = 8,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input logic       CLK,
  input logic       RESET,
  spike_tx_if.slave bus
);

  localparam int PKT_W      = pkt_width(NODE_ID_W, NEURON_ID_W, TS_W);
  localparam int ENTRY_W    = NEURON_ID_W + TS_W;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int TS_LSB     = ts_lsb();
  localparam int NEURON_LSB = neuron_lsb(TS_W);
  localparam int NODE_LSB   = node_lsb(NEURON_ID_W, TS_W);
  localparam int TYPE_LSB   = type_lsb(NODE_ID_W, NEURON_ID_W, TS_W);

  localparam logic [NODE_ID_W-1:0] NODE_ID_V = NODE_ID_W'(NODE_ID);
  localparam logic [15:0]          DROP_MAX  = 16'hFFFF;

  tx_state_e        state;
  tx_state_e        next_state;
  logic             ready_c;
  logic             in_ready;
  logic             spike_out;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [ENTRY_W-1:0] head;
  logic [PKT_W-1:0] pkt;
  logic [15:0]      drop_count;
`ifdef SPIKE_TX_EOT_EN
  logic             eot_out;
  logic [TS_W-1:0]  ts_closed;
`endif

  spike_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (push),
    .wr_data ({bus.spike_in_id, bus.timestep}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    spike_out  = 1'b0;
`ifdef SPIKE_TX_EOT_EN
    eot_out    = 1'b0;
`endif
    case (state)
      RUN: begin
        ready_c   = !fifo_full;
        spike_out = !fifo_empty;
        if (bus.timestep_done) next_state = DRAIN;
      end
      DRAIN: begin
        spike_out = !fifo_empty;
        if (fifo_empty) begin
`ifdef SPIKE_TX_EOT_EN
          next_state = EOT;
`else
          next_state = RUN;
`endif
        end
      end
`ifdef SPIKE_TX_EOT_EN
      EOT: begin
        eot_out = 1'b1;
        if (bus.pkt_ready) next_state = RUN;
      end
`endif
      default: next_state = RUN;
    endcase
  end

  // Spikes offered while reset is high are neither accepted nor reported ready.
  assign in_ready = ready_c && !RESET;
  assign push     = bus.spike_in_valid && in_ready;
  assign pop      = spike_out && bus.pkt_ready;

`ifdef SPIKE_TX_EOT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                  ts_closed <= '0;
    else if (state == RUN && bus.timestep_done) ts_closed <= bus.timestep;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drop_count <= '0;
    end else if (bus.spike_in_valid && !in_ready && drop_count != DROP_MAX) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Output mux: all-zero when nothing is presented; the head entry stays put
  // until popped, so a stalled packet holds stable.
  always_comb begin
    pkt = '0;
    if (spike_out) begin
      pkt[TYPE_LSB   +: 2]           = PKT_SPIKE;
      pkt[NODE_LSB   +: NODE_ID_W]   = NODE_ID_V;
      pkt[NEURON_LSB +: NEURON_ID_W] = head[TS_W +: NEURON_ID_W];
      pkt[TS_LSB     +: TS_W]        = head[0 +: TS_W];
    end
`ifdef SPIKE_TX_EOT_EN
    else if (eot_out) begin
      pkt[TYPE_LSB +: 2]         = PKT_EOT;
      pkt[NODE_LSB +: NODE_ID_W] = NODE_ID_V;
      pkt[TS_LSB   +: TS_W]      = ts_closed;
    end
`endif
  end

`ifdef SPIKE_TX_EOT_EN
  assign bus.pkt_valid = spike_out || eot_out;
`else
  assign bus.pkt_valid = spike_out;
`endif
  assign bus.pkt_data   = pkt;
  assign bus.in_ready   = in_ready;
  assign bus.fifo_count = fifo_count;
  assign bus.drop_count = drop_count;
  assign bus.busy       = (state != RUN) || !fifo_empty;

endmodule

// File: doc/spike_tx.md
# spike_tx

Spike transmitter for a neuromorphic NoC node: the sending end of the spike path whose receiving end feeds 4-bit `spike_in` vectors into the neuron accelerator. It collects per-neuron fire events (`spiked` plus neuron index) from the node's accelerator array and buffers them in a FIFO. It emits them as spike packets over a valid/ready link to the router's local port. At each timestep boundary it drains all buffered spikes, then optionally emits an end-of-timestep marker, so downstream nodes never mix spikes from two timesteps.

## Interface
Parameters:
- `NODE_ID_W`, 4: width of source node id field.
- `NODE_ID`, 0: this node's id, stamped into every packet.
- `NEURON_ID_W`, 8: neuron index width.
- `TS_W`, 8: timestep field width.
- `FIFO_DEPTH`, 8: spike FIFO entries; power of two, ≥2.

Ports (`PKT_W = 2+NODE_ID_W+NEURON_ID_W+TS_W`):
- `CLK` in 1: the single clock; all state on rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `spike_in_valid` in 1: a neuron fired this cycle.
- `spike_in_id` in `NEURON_ID_W`: index of the firing neuron.
- `timestep` in `TS_W`: current timestep, sampled with each accepted spike.
- `timestep_done` in 1: single-cycle pulse closing the current timestep.
- `in_ready` out 1: spike will be accepted this cycle.
- `pkt_valid` out 1: packet available.
- `pkt_ready` in 1: router accepts packet.
- `pkt_data` out `PKT_W`: `{type[1:0], NODE_ID, neuron_id, ts}`.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: buffered spikes.
- `drop_count` out 16: spikes lost, saturating.
- `busy` out 1: state ≠ RUN or FIFO non-empty.

## Operation
- Packet types: SPIKE = 2'b01, EOT = 2'b10. EOT carries neuron_id = 0 and ts = closed timestep.
- FSM states: RUN, DRAIN, EOT.
  - RUN: `in_ready = !full`. On `timestep_done`, latch `timestep` into `ts_closed` and go to DRAIN.
  - DRAIN: `in_ready = 0`. FIFO forwards entries. When empty, go to EOT, or to RUN without the macro.
  - EOT: present the EOT packet. On `pkt_valid && pkt_ready`, go to RUN.
- Push: `spike_in_valid && in_ready` writes `{neuron_id, timestep}`.
- Drop: `spike_in_valid && !in_ready` discards the spike and increments `drop_count`, saturating at 16'hFFFF.
- Full and pop in the same cycle: the push is still dropped, because `in_ready` depends only on `!full`.
- `timestep_done` with spike in the same cycle (RUN): the spike is pushed, counts in the closing timestep, and is sent before EOT.
- `timestep_done` in DRAIN or EOT: ignored.
- Output in RUN/DRAIN: `pkt_valid = !empty`, `pkt_data` = head entry, pop on handshake.
- `pkt_data` is 0 whenever `pkt_valid` = 0. It must hold stable while `pkt_valid && !pkt_ready`.

## Timing
- Reset values: `pkt_valid` 0, `pkt_data` 0, `fifo_count` 0, `drop_count` 0, `busy` 0, state RUN. `in_ready` is 1 once `RESET` deasserts; inputs are ignored while `RESET` is high.
- Latency: a spike accepted at edge N gives `pkt_valid` = 1 after edge N (cycle N+1). Throughput is 1 packet/cycle.
- `timestep_done` with an empty FIFO: DRAIN lasts one cycle, then EOT.
- Reset mid-DRAIN/EOT: FIFO is flushed, no EOT is sent, state is RUN.
- `fifo_count` reaches `FIFO_DEPTH` at full; pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `SPIKE_TX_EOT_EN` defined: EOT state exists; one EOT packet follows every drained timestep.
- `SPIKE_TX_EOT_EN` undefined: EOT state and type are removed; DRAIN returns directly to RUN when the FIFO empties. `in_ready` is still 0 during DRAIN.

## Structure
- Package `spike_pkg`: packet type constants `PKT_SPIKE`/`PKT_EOT`, FSM state enum, field-offset helpers for `pkt_data`.
- Sub-module `spike_fifo`: synchronous FIFO (`WIDTH`, `DEPTH`) with full/empty/count outputs. `spike_tx` contains the FSM, drop counter and output mux.

## Test plan
- Reset, then spike id 5 at ts 3 with `pkt_ready`=1 → next cycle `pkt_data` = `{01, NODE_ID, 8'd5, 8'd3}`; `fifo_count` returns to 0.
- `pkt_ready`=0, push 10 spikes (`FIFO_DEPTH`=8) → `fifo_count`=8, `in_ready`=0, `drop_count`=2; `pkt_data` stable on the first spike.
- 3 spikes, then `timestep_done` at ts 7 → the 3 SPIKE packets in order, then one EOT `{10, NODE_ID, 0, 7}`; spikes offered during DRAIN increase `drop_count`.
- Spike and `timestep_done` in the same cycle → that spike is sent before EOT; a second `timestep_done` during DRAIN produces no extra EOT.
- Assert `RESET` during EOT with `pkt_ready`=0 → all outputs 0, no EOT sent afterwards, `in_ready`=1 after release.
- Build without `SPIKE_TX_EOT_EN`: `timestep_done` → spikes drain, no EOT packet, `busy` falls when the FIFO empties.
